// File: rtl/half_period_pkg.sv
// Shared types and helpers for the half-period toggle generator.
package half_period_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } hp_state_e;

    localparam int unsigned DEF_HALF_C = 100;

    // A half period of zero cycles is meaningless; treat it as one.
    function automatic logic [31:0] sat_half(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/hp_down_counter.sv
// Loadable down-counter that holds at zero and flags it.
module hp_down_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/half_period_toggle_gen.sv
// Clock-counted square-wave generator with edge strobes, an edge counter and a
// one-entry config buffer so the half period can be changed glitch-free.
module half_period_toggle_gen
    import half_period_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = DEF_HALF_C
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_half_i,
    output logic             tog_o,
    output logic             tog_rise_o,
    output logic             tog_fall_o,
    output logic [31:0]      edge_cnt_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    // Config port: a value transfers on cfg_valid_i && cfg_ready_o; cfg_ready_o
    // is low exactly while a value waits in the buffer for the next toggle edge.

    localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(sat_half(32'(DEF_HALF)));

    hp_state_e        state_q, state_d;
    logic             tog_q, tog_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [31:0]      edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] act_half_q, act_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_vld_q, pend_vld_d;

    logic             accept;
    logic             toggle;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cfg_sat;
    logic [CNT_W-1:0] reload_half;
    logic [CNT_W-1:0] cnt_load_val;

    hp_down_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        accept       = cfg_valid_i & ~pend_vld_q;
        cfg_sat      = CNT_W'(sat_half(32'(cfg_half_i)));
        state_d      = state_q;
        tog_d        = tog_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        edge_cnt_d   = edge_cnt_q;
        act_half_d   = act_half_q;
        pend_half_d  = pend_half_q;
        pend_vld_d   = pend_vld_q;
        toggle       = 1'b0;
        cnt_dec      = 1'b0;
        reload_half  = act_half_q;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    toggle  = 1'b1;
                    tog_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (cnt_zero) begin
                    toggle = 1'b1;
                    tog_d  = ~tog_q;
                    if (pend_vld_q) begin
                        reload_half = pend_half_q;
                        act_half_d  = pend_half_q;
                        pend_vld_d  = 1'b0;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
                // The stop decision looks at the level after this edge's toggle.
                if (state_q == DRAIN) begin
                    if (cnt_zero) begin
                        state_d = IDLE;
                    end
                end else if (!en_i) begin
                    state_d = tog_d ? DRAIN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (toggle) begin
            edge_cnt_d = edge_cnt_q + 32'd1;
            rise_d     = tog_d;
            fall_d     = ~tog_d;
        end

        if ((state_q != IDLE) && (state_d == IDLE) && pend_vld_q) begin
            act_half_d = pend_half_q;
            pend_vld_d = 1'b0;
        end

        // A value arriving while idle (or as we go idle) needs no buffering.
        if (accept) begin
            if ((state_q == IDLE) || (state_d == IDLE)) begin
                act_half_d = cfg_sat;
            end else begin
                pend_half_d = cfg_sat;
                pend_vld_d  = 1'b1;
            end
        end

        cnt_load     = toggle;
        cnt_load_val = reload_half - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tog_q       <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            edge_cnt_q  <= 32'd0;
            act_half_q  <= DEF_HALF_W;
            pend_half_q <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tog_q       <= tog_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            edge_cnt_q  <= edge_cnt_d;
            act_half_q  <= act_half_d;
            pend_half_q <= pend_half_d;
            pend_vld_q  <= pend_vld_d;
        end
    end

    assign cfg_ready_o = ~pend_vld_q;
    assign tog_o       = tog_q;
    assign tog_rise_o  = rise_q;
    assign tog_fall_o  = fall_q;
    assign edge_cnt_o  = edge_cnt_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_half_period_toggle_gen.sv
// Bench for half_period_toggle_gen: timestamp-based reference model plus
// directed scenarios with hand-computed timings and a randomized soak.
module tb_half_period_toggle_gen;

    localparam int LIM = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_half = '0;
    logic        cfg_ready;
    logic        tog;
    logic        tog_rise;
    logic        tog_fall;
    logic [31:0] edge_cnt;
    logic        busy;
    logic [1:0]  state;

    int     n_tests = 0;
    int     n_fail = 0;
    bit     chk_on = 1'b0;
    longint tb_cyc = 0;

    half_period_toggle_gen #(
        .CNT_W    (16),
        .DEF_HALF (100)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_half_i  (cfg_half),
        .tog_o       (tog),
        .tog_rise_o  (tog_rise),
        .tog_fall_o  (tog_fall),
        .edge_cnt_o  (edge_cnt),
        .busy_o      (busy),
        .state_o     (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc++;

    // ---------------- reference model: absolute timestamp of next edge ----------------
    bit          m_tog, m_rise, m_fall, m_busy, m_drain, m_was, m_acc;
    logic [31:0] m_edges;
    int          m_act, m_v;
    longint      m_cyc = 0;
    longint      m_next;
    int          m_pend[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tog = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_drain = 0;
            m_edges = 0; m_act = 100; m_pend.delete();
        end else begin
            m_was = m_busy;
            m_acc = cfg_valid && (m_pend.size() == 0);
            m_v = (cfg_half == 0) ? 1 : int'(cfg_half);
            m_rise = 0;
            m_fall = 0;
            if (!m_busy) begin
                if (en) begin
                    m_busy = 1; m_drain = 0; m_tog = 1; m_rise = 1;
                    m_edges = m_edges + 1;
                    m_next = m_cyc + m_act;
                end
            end else begin
                if (m_cyc == m_next) begin
                    m_tog = !m_tog;
                    if (m_tog) m_rise = 1; else m_fall = 1;
                    m_edges = m_edges + 1;
                    if (m_pend.size() != 0) m_act = m_pend.pop_front();
                    m_next = m_cyc + m_act;
                    if (m_drain) m_busy = 0;
                end
                if (m_busy && !m_drain && !en) begin
                    if (m_tog) m_drain = 1; else m_busy = 0;
                end
                if (!m_busy && m_pend.size() != 0) m_act = m_pend.pop_front();
            end
            if (m_acc) begin
                if (m_was && m_busy) m_pend.push_back(m_v);
                else m_act = m_v;
            end
            m_cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("tog", 32'(tog), 32'(m_tog));
            check("tog_rise", 32'(tog_rise), 32'(m_rise));
            check("tog_fall", 32'(tog_fall), 32'(m_fall));
            check("edge_cnt", edge_cnt, m_edges);
            check("busy", 32'(busy), 32'(m_busy));
            check("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
        end
    end

    // ---------------- bounded waits ----------------
    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles, one required", name, LIM);
    endtask

    task automatic wait_rise(output longint c);
        c = -1;
        for (int k = 0; k < LIM; k++) begin
            @(negedge clk);
            if (tog_rise) begin c = tb_cyc; break; end
        end
        if (c < 0) timeout("wait_rise");
    endtask

    task automatic wait_fall(output longint c);
        c = -1;
        for (int k = 0; k < LIM; k++) begin
            @(negedge clk);
            if (tog_fall) begin c = tb_cyc; break; end
        end
        if (c < 0) timeout("wait_fall");
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < LIM; k++) begin
            @(negedge clk);
            if (!busy) begin done = 1; break; end
        end
        if (!done) timeout("wait_idle");
    endtask

    task automatic wait_edge();
        bit done = 0;
        for (int k = 0; k < LIM; k++) begin
            @(negedge clk);
            if (tog_rise || tog_fall) begin done = 1; break; end
        end
        if (!done) timeout("wait_edge");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        longint r, f, r2, f2, rel;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_tog", 32'(tog), 0);
        check("rst_edges", edge_cnt, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cfg_ready), 1);

        // Release with en high: rise next edge, 100-cycle phases.
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rel = tb_cyc;
        wait_rise(r);
        check("first_rise_latency", 32'(r - rel), 1);
        wait_fall(f);
        check("high_len_def", 32'(f - r), 100);
        wait_rise(r2);
        check("period_def", 32'(r2 - r), 200);
        repeat (1799) @(negedge clk);
        check("edges_10_periods", edge_cnt, 20);

        // Retarget to 3 mid-high-phase; a second offer stalls.
        wait_rise(r);
        repeat (10) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_half = 16'd3;
        @(negedge clk);
        cfg_half = 16'd5;
        check("ready_after_accept", 32'(cfg_ready), 0);
        repeat (20) @(negedge clk);
        check("ready_stalled", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        wait_fall(f);
        check("phase_before_apply", 32'(f - r), 100);
        check("ready_at_apply", 32'(cfg_ready), 1);
        wait_rise(r2);
        check("low_after_apply", 32'(r2 - f), 3);
        wait_fall(f2);
        check("high_after_apply", 32'(f2 - r2), 3);

        // Zero half period in IDLE behaves as 1.
        en = 1'b0;
        wait_idle();
        cfg_valid = 1'b1;
        cfg_half = 16'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("h1_tog", 32'(tog), 32'(i % 2 == 0));
            check("h1_rise", 32'(tog_rise), 32'(i % 2 == 0));
            check("h1_fall", 32'(tog_fall), 32'(i % 2 == 1));
            @(negedge clk);
        end

        // Drop en 40 cycles into a 100-cycle high phase: drain to the fall.
        cfg_valid = 1'b1;
        cfg_half = 16'd100;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        wait_rise(r);
        repeat (39) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drain_entered", 32'(state), 2);
        wait_fall(f);
        check("drain_fall", 32'(f - r), 100);
        check("drain_busy", 32'(busy), 0);

        // Drop en during a low phase: straight to IDLE.
        en = 1'b1;
        wait_fall(f);
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("stop_low_busy", 32'(busy), 0);
        check("stop_low_tog", 32'(tog), 0);
        repeat (5) @(negedge clk);
        check("stop_low_quiet", 32'(tog), 0);

        // Asynchronous reset with a pending config.
        en = 1'b1;
        wait_rise(r);
        repeat (5) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_half = 16'd7;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("pend_ready", 32'(cfg_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_tog", 32'(tog), 0);
        check("arst_rise", 32'(tog_rise), 0);
        check("arst_edges", edge_cnt, 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(cfg_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_rise(r);
        wait_fall(f);
        check("post_rst_half", 32'(f - r), 100);

        // Randomized soak with short half periods.
        cfg_valid = 1'b1;
        cfg_half = 16'd2;
        @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_half = 16'($urandom_range(0, 6));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        en = 1'b1;
        repeat (20) @(negedge clk);

        // Edge counter wraps from all-ones to zero.
        #1 force dut.edge_cnt_q = 32'hFFFF_FFFF;
        m_edges = 32'hFFFF_FFFF;
        #1 release dut.edge_cnt_q;
        wait_edge();
        check("edge_wrap", edge_cnt, 0);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
